// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline boundary of the LEGv8 datapath. Captures decoded control and
// operands from the decode stage and presents them to the EX stage (ALUOp and
// opcode to the ALU control block, operands to the ALU). It also:
//   - detects load-use hazards and inserts a single bubble while stalling IF/ID
//   - honours a downstream hold (stall_in) and a taken-branch flush
//   - counts inserted hazard bubbles in a saturating performance counter
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   id_valid                decode slot holds a real instruction
//   id_ALUOp, id_opcode     ALU op class and opcode bits [31:21]
//   id_ALUSrc .. id_Branch  decoded control bits
//   id_rn, id_rm, id_rd     register specifiers
//   id_uses_rn, id_uses_rm  source register actually read
//   id_rdata1, id_rdata2    register-file read data
//   id_imm                  sign-extended immediate
//   stall_in                MEM requests the pipeline hold
//   flush                   branch resolved taken; kill ID and EX contents
//   ex_*                    registered copies of the id_* fields
//   stall_out               combinational; IF/ID must hold this cycle
//   bubble_count            hazard bubbles inserted since reset (saturating)
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                id_valid,
  input  logic [1:0]          id_ALUOp,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                id_ALUSrc,
  input  logic                id_MemRead,
  input  logic                id_MemWrite,
  input  logic                id_RegWrite,
  input  logic                id_MemtoReg,
  input  logic                id_Branch,
  input  logic [REG_W-1:0]    id_rn,
  input  logic [REG_W-1:0]    id_rm,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_uses_rn,
  input  logic                id_uses_rm,
  input  logic [DATA_W-1:0]   id_rdata1,
  input  logic [DATA_W-1:0]   id_rdata2,
  input  logic [DATA_W-1:0]   id_imm,

  input  logic                stall_in,
  input  logic                flush,

  output logic                ex_valid,
  output logic [1:0]          ex_ALUOp,
  output logic [OPCODE_W-1:0] ex_opcode,
  output logic                ex_ALUSrc,
  output logic                ex_MemRead,
  output logic                ex_MemWrite,
  output logic                ex_RegWrite,
  output logic                ex_MemtoReg,
  output logic                ex_Branch,
  output logic [REG_W-1:0]    ex_rn,
  output logic [REG_W-1:0]    ex_rm,
  output logic [REG_W-1:0]    ex_rd,
  output logic [DATA_W-1:0]   ex_rdata1,
  output logic [DATA_W-1:0]   ex_rdata2,
  output logic [DATA_W-1:0]   ex_imm,

  output logic                stall_out,
  output logic [CNT_W-1:0]    bubble_count
);

  // XZR: reads as zero and is never written, so it can never carry a hazard.
  localparam logic [REG_W-1:0] XZR = '1;

  // Everything a bubble clears. ex_opcode is included so a bubble presents a
  // fully quiet control word to the ALU control block.
  typedef struct packed {
    logic                valid;
    logic [1:0]          alu_op;
    logic [OPCODE_W-1:0] opcode;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                branch;
  } ctl_t;

  // Specifiers and operands; these hold through a bubble.
  typedef struct packed {
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
  } dat_t;

  ctl_t             ctl_d, ctl_q, id_ctl;
  dat_t             dat_d, dat_q, id_dat;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hazard;

  assign id_ctl = '{valid:      id_valid,
                    alu_op:     id_ALUOp,
                    opcode:     id_opcode,
                    alu_src:    id_ALUSrc,
                    mem_read:   id_MemRead,
                    mem_write:  id_MemWrite,
                    reg_write:  id_RegWrite,
                    mem_to_reg: id_MemtoReg,
                    branch:     id_Branch};

  assign id_dat = '{rn: id_rn, rm: id_rm, rd: id_rd,
                    rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm};

  // Load in EX whose destination is read by the instruction sitting in ID.
  assign hazard = ctl_q.valid & ctl_q.mem_read & (dat_q.rd != XZR) & id_valid &
                  ((id_uses_rn & (id_rn == dat_q.rd)) |
                   (id_uses_rm & (id_rm == dat_q.rd)));

  // A flush kills the ID instruction, so there is nothing left to hold.
  assign stall_out = ~flush & (stall_in | hazard);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // priority chain leaves it unassigned, which would infer a latch.
    ctl_d = ctl_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (flush) begin
      ctl_d = '0;
    end else if (stall_in) begin
      // hold everything, including a load whose consumer is waiting
    end else if (hazard) begin
      ctl_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      dat_d = id_dat;
      // An empty decode slot must never leak stray control into EX.
      ctl_d = id_valid ? id_ctl : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      ctl_q <= ctl_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ctl_q.valid;
  assign ex_ALUOp     = ctl_q.alu_op;
  assign ex_opcode    = ctl_q.opcode;
  assign ex_ALUSrc    = ctl_q.alu_src;
  assign ex_MemRead   = ctl_q.mem_read;
  assign ex_MemWrite  = ctl_q.mem_write;
  assign ex_RegWrite  = ctl_q.reg_write;
  assign ex_MemtoReg  = ctl_q.mem_to_reg;
  assign ex_Branch    = ctl_q.branch;
  assign ex_rn        = dat_q.rn;
  assign ex_rm        = dat_q.rm;
  assign ex_rd        = dat_q.rd;
  assign ex_rdata1    = dat_q.rdata1;
  assign ex_rdata2    = dat_q.rdata2;
  assign ex_imm       = dat_q.imm;
  assign bubble_count = cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline boundary of the LEGv8 datapath.
- Registers decoded control and operands from the decode stage. Drives the EX stage, i.e. ALUOp/opcode into the ALU control block and operands into the ALU.
- Contains load-use hazard detection: inserts a one-cycle bubble and stalls upstream.
- Honours downstream hold and branch flush, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 64, operand and immediate width.
- REG_W, 5, register specifier width.
- OPCODE_W, 11, instruction opcode field width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_ALUOp  in  2  ALU op class (00 add/addr, 01 pass-B/CBZ, 10 R-type via opcode)
- id_opcode  in  OPCODE_W  instruction opcode bits [31:21]
- id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch  in  1 each  decoded control
- id_rn, id_rm, id_rd  in  REG_W  register specifiers
- id_uses_rn, id_uses_rm  in  1  source actually read by the instruction
- id_rdata1, id_rdata2, id_imm  in  DATA_W  register-file reads, sign-extended immediate
- stall_in  in  1  downstream (MEM) requests hold
- flush  in  1  branch resolved taken; kill ID and EX contents
- ex_valid  out  1  EX slot holds a real instruction
- ex_ALUOp, ex_opcode, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch  out  as inputs  registered control
- ex_rn, ex_rm, ex_rd  out  REG_W  registered specifiers
- ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered data
- stall_out  out  1  combinational; IF/ID must hold this cycle
- bubble_count  out  CNT_W  hazard bubbles inserted since reset

Behaviour:
- Reset (asynchronous, reset_n=0): every registered output is 0, including ex_valid, ex_rd and bubble_count. Reset mid-stall discards the held instruction.
- hazard (combinational) = ex_valid & ex_MemRead & (ex_rd != 31) & id_valid & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). Register 31 is XZR, so it never hazards.
- stall_out = !flush & (stall_in | hazard).
- Update at each posedge, first matching rule wins:
  1. flush: bubble. ex_valid and all control outputs go to 0; data and specifier registers hold. The counter does not increment.
  2. stall_in: all EX registers hold, including a held load. The counter does not increment.
  3. hazard: bubble, as in rule 1. bubble_count increments, saturating at all-ones.
  4. otherwise: load all id_* into ex_*; ex_valid = id_valid. When id_valid=0, control outputs are forced to 0 regardless of the id_* control values.
- Bubble semantics: every control output is 0, so the ALU control block sees ALUOp=00 and opcode is don't-care. No memory or register write occurs.
- Latency is one cycle ID to EX.
- A load-use hazard costs exactly one bubble. The bubble clears ex_MemRead, so hazard deasserts the next cycle and the held ID instruction then loads.
- Back-to-back dependent loads: each consumer gets its own single bubble.
- hazard with stall_in: hold wins and stall_out=1. The bubble is inserted on the first cycle stall_in is low and hazard is still true.
- flush with stall_in or hazard: flush wins and stall_out=0.
- No combinational path from id_* data to ex_* outputs. stall_out is the only combinational output.

Test Plan:
- Reset: reset_n=0 asynchronously with clk idle -> all outputs 0 immediately. Release, then drive an ADD (ALUOp=10, opcode=ADD, rdata1=5, rdata2=7, rd=3) -> one edge later ex_* match the inputs, ex_valid=1, stall_out=0.
- Load-use: LDUR X2 enters EX (MemRead=1, rd=2); ID holds SUB with rn=2, uses_rn=1 -> stall_out=1. Next edge: ex_valid=0, controls 0, bubble_count=1. Following edge: SUB in EX, stall_out=0.
- No false hazard: LDUR rd=31 followed by a consumer with rn=31 -> no bubble. LDUR rd=4 followed by a consumer with rm=4, uses_rm=0 -> no bubble. bubble_count stays 0 in both cases.
- Hold: stall_in=1 for 3 cycles with a hazard pending -> EX keeps the LDUR unchanged, stall_out=1 throughout. After release, exactly one bubble is inserted and bubble_count increments by 1.
- Flush priority: flush=1 together with hazard=1 and stall_in=1 -> stall_out=0. Next edge: ex_valid=0, ex_RegWrite=0, bubble_count unchanged.
- Saturation: force 65,540 load-use bubbles -> bubble_count stops at 16'hFFFF. Reset mid-sequence -> counter returns to 0 asynchronously.
